regfile_write_scheduler: RTL

- Shares the register file's single write port between two writeback requesters (R0 = ALU, R1 = load unit) using round-robin arbitration with valid/ready handshakes.
- Keeps a per-register pending-write scoreboard and drives the register file's select, data and read/write control.
- Flags read hazards on the A and B read selects so issue logic can stall.
- Sits between the writeback sources and the register file, alongside the decode and issue logic.

---
 rtl/regfile_write_scheduler.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/regfile_write_scheduler.sv
// Register-file write-port scheduler.
// Two writeback sources (R0 = ALU, R1 = load unit) share the single write
// port through a round-robin arbiter. Each accepted request goes through one
// registered write stage that drives the register file.
// A per-register scoreboard tracks reserved destinations. Read hazards on
// ports A and B are flagged so that issue logic can stall.
module regfile_write_scheduler #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_REGS   = 4,
    parameter int SEL_WIDTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  reqValid0,
    input  logic [SEL_WIDTH-1:0]  reqSel0,
    input  logic [DATA_WIDTH-1:0] reqData0,
    output logic                  reqReady0,
    input  logic                  reqValid1,
    input  logic [SEL_WIDTH-1:0]  reqSel1,
    input  logic [DATA_WIDTH-1:0] reqData1,
    output logic                  reqReady1,
    input  logic                  reserveValid,
    input  logic [SEL_WIDTH-1:0]  reserveSel,
    input  logic [SEL_WIDTH-1:0]  readSelA,
    input  logic [SEL_WIDTH-1:0]  readSelB,
    output logic                  readStall,
    output logic [NUM_REGS-1:0]   busy,
    output logic                  reserveConflict,
    output logic [SEL_WIDTH-1:0]  rfSelWrite,
    output logic [DATA_WIDTH-1:0] rfWriteIn,
    output logic                  rfIsReading
);

    // Priority pointer: 0 favours R0, 1 favours R1 when both sides are valid.
    logic                  ptr_q, ptr_d;
    logic                  grant0, grant1, accept;
    // The write stage is valid exactly when rf_is_reading_q is low.
    logic                  rf_is_reading_q, rf_is_reading_d;
    logic [SEL_WIDTH-1:0]  rf_sel_q, rf_sel_d;
    logic [DATA_WIDTH-1:0] rf_data_q, rf_data_d;
    logic [NUM_REGS-1:0]   busy_q, busy_d;
    logic                  conflict_q, conflict_d;

    // Round-robin grant from the registered pointer; ready is the grant itself.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (reqValid0 && reqValid1) begin
            if (ptr_q == 1'b0) begin
                grant0 = 1'b1;
            end else begin
                grant1 = 1'b1;
            end
        end else if (reqValid0) begin
            grant0 = 1'b1;
        end else if (reqValid1) begin
            grant1 = 1'b1;
        end else begin
            grant0 = 1'b0;
            grant1 = 1'b0;
        end
        accept = grant0 | grant1;
    end

    assign reqReady0 = grant0;
    assign reqReady1 = grant1;

    // Pointer moves to the side that lost; it holds when nothing is granted.
    always_comb begin
        ptr_d = ptr_q;
        if (grant0) begin
            ptr_d = 1'b1;
        end else if (grant1) begin
            ptr_d = 1'b0;
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Write-stage capture; sel/data hold their last values while idle.
    always_comb begin
        rf_sel_d        = rf_sel_q;
        rf_data_d       = rf_data_q;
        rf_is_reading_d = ~accept;
        if (grant1) begin
            rf_sel_d  = reqSel1;
            rf_data_d = reqData1;
        end else if (grant0) begin
            rf_sel_d  = reqSel0;
            rf_data_d = reqData0;
        end else begin
            rf_sel_d  = rf_sel_q;
            rf_data_d = rf_data_q;
        end
    end

    // Scoreboard update: the write clears first, so a same-cycle reservation wins.
    always_comb begin
        busy_d     = busy_q;
        conflict_d = reserveValid & busy_q[reserveSel];
        if (!rf_is_reading_q) begin
            busy_d[rf_sel_q] = 1'b0;
        end else begin
            busy_d = busy_q;
        end
        if (reserveValid) begin
            busy_d[reserveSel] = 1'b1;
        end else begin
            busy_d[reserveSel] = busy_d[reserveSel];
        end
    end

    // All state is held in flops with an asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q           <= 1'b0;
            rf_is_reading_q <= 1'b1;
            rf_sel_q        <= {SEL_WIDTH{1'b0}};
            rf_data_q       <= {DATA_WIDTH{1'b0}};
            busy_q          <= {NUM_REGS{1'b0}};
            conflict_q      <= 1'b0;
        end else begin
            ptr_q           <= ptr_d;
            rf_is_reading_q <= rf_is_reading_d;
            rf_sel_q        <= rf_sel_d;
            rf_data_q       <= rf_data_d;
            busy_q          <= busy_d;
            conflict_q      <= conflict_d;
        end
    end

    assign rfIsReading     = rf_is_reading_q;
    assign rfSelWrite      = rf_sel_q;
    assign rfWriteIn       = rf_data_q;
    assign busy            = busy_q;
    assign reserveConflict = conflict_q;
    // A register stays busy through its write cycle; the stall lifts the cycle after.
    assign readStall       = busy_q[readSelA] | busy_q[readSelB];

endmodule
